hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose: pipeline interlock for a five-stage in-order pipeline. Tracks the
// destinations of the instructions in EX, MEM and WB with a small shift-register
// scoreboard, stalls decode on read-after-write hazards, squashes fetch/decode
// on a taken branch and counts stall cycles and flushes.
//
// Parameters:
//   WB_BYPASS  1 = register file writes through to same-cycle reads, so the
//              WB slot never causes a hazard
//   CNT_W      width of the saturating performance counters
//
// Ports:
//   stg_clk                      pipeline clock, rising edge
//   reset                        synchronous active-high reset
//   dec_valid                    instruction present in decode
//   dec_rs1/dec_rs2              decode source registers
//   dec_rs1_used/dec_rs2_used    source is actually read
//   dec_rd, dec_save_to_reg      decode destination and write enable
//   ex_branch_taken              branch resolved taken in EX this cycle
//   mem_busy                     global pipeline hold
//   if_ena/if_x                  fetch latch enable / bubble insert
//   id_ena/id_x                  decode latch enable / bubble insert
//   issue                        decode instruction advances into EX
//   stall_cycles                 saturating count of hazard-stall cycles
//   flush_events                 saturating count of taken-branch flushes
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 16
) (
  input  logic             stg_clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [4:0]       dec_rd,
  input  logic             dec_save_to_reg,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             if_ena,
  output logic             if_x,
  output logic             id_ena,
  output logic             id_x,
  output logic             issue,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic             CheckWb = (WB_BYPASS == 0);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e           state_q, state_d;
  // Scoreboard slot 0 = EX, 1 = MEM, 2 = WB
  logic [2:0]       sbWr_q, sbWr_d;
  logic [4:0]       sbRd_q [3];
  logic [4:0]       sbRd_d [3];
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic             rs1Hit, rs2Hit, hazard;
  logic             stallCase, flushCase;

  // x0 is hard-wired to zero, so a write to it never creates a dependence
  function automatic logic slotMatch(input logic wr, input logic [4:0] rd,
                                     input logic [4:0] src);
    return wr && (rd == src) && (src != 5'd0);
  endfunction

  // Compare each used source against the in-flight destinations; the WB slot
  // only counts when the register file cannot forward a same-cycle write
  always_comb begin
    rs1Hit = slotMatch(sbWr_q[0], sbRd_q[0], dec_rs1) |
             slotMatch(sbWr_q[1], sbRd_q[1], dec_rs1) |
             (CheckWb & slotMatch(sbWr_q[2], sbRd_q[2], dec_rs1));
    rs2Hit = slotMatch(sbWr_q[0], sbRd_q[0], dec_rs2) |
             slotMatch(sbWr_q[1], sbRd_q[1], dec_rs2) |
             (CheckWb & slotMatch(sbWr_q[2], sbRd_q[2], dec_rs2));
    hazard = dec_valid & ((dec_rs1_used & rs1Hit) | (dec_rs2_used & rs2Hit));
  end

  // Pipeline control outputs in strict priority: reset, global hold, taken
  // branch, post-branch flush cycle, hazard stall, normal flow. The stall and
  // flush case flags feed the performance counters.
  always_comb begin
    if_ena    = 1'b1;
    if_x      = 1'b0;
    id_ena    = 1'b1;
    id_x      = 1'b0;
    issue     = 1'b0;
    stallCase = 1'b0;
    flushCase = 1'b0;
    if (reset) begin
      if_ena = 1'b0;
      id_ena = 1'b0;
      if_x   = 1'b1;
      id_x   = 1'b1;
    end else if (mem_busy) begin
      if_ena = 1'b0;
      id_ena = 1'b0;
    end else if (ex_branch_taken) begin
      if_x      = 1'b1;
      id_x      = 1'b1;
      flushCase = 1'b1;
    end else if (state_q == FLUSH) begin
      // The instruction now in D was squashed last cycle: bubble it into EX
      // while fetch refills from the branch target
      id_x = 1'b1;
    end else if (hazard) begin
      if_ena    = 1'b0;
      id_x      = 1'b1;
      stallCase = 1'b1;
    end else begin
      issue = dec_valid;
    end
  end

  // Next state, scoreboard shift and counter increments. These are only
  // committed when the pipeline is not held.
  always_comb begin
    state_d = RUN;
    if (ex_branch_taken) begin
      state_d = FLUSH;
    end else if (hazard) begin
      state_d = STALL;
    end

    sbWr_d    = {sbWr_q[1:0], issue & dec_save_to_reg & (dec_rd != 5'd0)};
    sbRd_d[2] = sbRd_q[1];
    sbRd_d[1] = sbRd_q[0];
    sbRd_d[0] = issue ? dec_rd : 5'd0;

    stallCnt_d = stallCnt_q;
    if (stallCase && (stallCnt_q != CntMax)) begin
      stallCnt_d = stallCnt_q + CntOne;
    end
    flushCnt_d = flushCnt_q;
    if (flushCase && (flushCnt_q != CntMax)) begin
      flushCnt_d = flushCnt_q + CntOne;
    end
  end

  // State register: reset discards every pending scoreboard entry; mem_busy
  // freezes the whole block including the counters
  always_ff @(posedge stg_clk) begin
    if (reset) begin
      state_q    <= RUN;
      sbWr_q     <= '0;
      sbRd_q     <= '{default: '0};
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else if (!mem_busy) begin
      state_q    <= state_d;
      sbWr_q     <= sbWr_d;
      sbRd_q     <= sbRd_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cycles = stallCnt_q;
  assign flush_events = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Drives three hazard_ctrl instances from the same inputs: the default
// configuration, one with WB_BYPASS=1 and one with 2-bit counters. A directed
// vector table targets the main instance; every cycle all three instances are
// also compared against a timestamp-based reference model.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [4:0] RST = 5'b01010;
  localparam logic [4:0] BSY = 5'b00000;
  localparam logic [4:0] BRN = 5'b11110;
  localparam logic [4:0] FLS = 5'b10110;
  localparam logic [4:0] STL = 5'b00110;
  localparam logic [4:0] ISS = 5'b10101;
  localparam logic [4:0] IDL = 5'b10100;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       save;
    logic       br;
    logic       busy;
    logic       chk;
    logic [4:0] expOut;
    int         expStall;
    int         expFlush;
  } vec_t;

  logic       stg_clk = 1'b0;
  logic       reset, dec_valid, dec_rs1_used, dec_rs2_used;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_save_to_reg, ex_branch_taken, mem_busy;

  logic        ifEnaA, ifXA, idEnaA, idXA, issueA;
  logic        ifEnaB, ifXB, idEnaB, idXB, issueB;
  logic        ifEnaS, ifXS, idEnaS, idXS, issueS;
  logic [15:0] stallA, flushA, stallB, flushB;
  logic [1:0]  stallS, flushS;

  logic [4:0]  outs   [3];
  logic [31:0] dutStl [3];
  logic [31:0] dutFls [3];

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a source is hazardous when its latest writer issued
  // within the last `window` advancing clock edges
  int window [3] = '{3, 2, 3};
  int cntMax [3] = '{65535, 65535, 3};
  int lastWrite [3][32];
  int advCount  [3];
  bit flushPrev [3];
  int mStall    [3];
  int mFlush    [3];

  vec_t tbl [$];

  always #5 stg_clk = ~stg_clk;

  hazard_ctrl #(.WB_BYPASS(0), .CNT_W(16)) dutA (
    .stg_clk(stg_clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_save_to_reg(dec_save_to_reg),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .if_ena(ifEnaA), .if_x(ifXA), .id_ena(idEnaA), .id_x(idXA),
    .issue(issueA), .stall_cycles(stallA), .flush_events(flushA)
  );

  hazard_ctrl #(.WB_BYPASS(1), .CNT_W(16)) dutB (
    .stg_clk(stg_clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_save_to_reg(dec_save_to_reg),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .if_ena(ifEnaB), .if_x(ifXB), .id_ena(idEnaB), .id_x(idXB),
    .issue(issueB), .stall_cycles(stallB), .flush_events(flushB)
  );

  hazard_ctrl #(.WB_BYPASS(0), .CNT_W(2)) dutS (
    .stg_clk(stg_clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_save_to_reg(dec_save_to_reg),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .if_ena(ifEnaS), .if_x(ifXS), .id_ena(idEnaS), .id_x(idXS),
    .issue(issueS), .stall_cycles(stallS), .flush_events(flushS)
  );

  assign outs[0]   = {ifEnaA, ifXA, idEnaA, idXA, issueA};
  assign outs[1]   = {ifEnaB, ifXB, idEnaB, idXB, issueB};
  assign outs[2]   = {ifEnaS, ifXS, idEnaS, idXS, issueS};
  assign dutStl[0] = {16'd0, stallA};
  assign dutStl[1] = {16'd0, stallB};
  assign dutStl[2] = {30'd0, stallS};
  assign dutFls[0] = {16'd0, flushA};
  assign dutFls[1] = {16'd0, flushB};
  assign dutFls[2] = {30'd0, flushS};

  function automatic vec_t mkVec(logic rst, logic valid, logic [4:0] rs1,
                                 logic [4:0] rs2, logic u1, logic u2,
                                 logic [4:0] rd, logic save, logic br,
                                 logic busy);
    vec_t v;
    v.rst = rst; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.rd = rd; v.save = save; v.br = br; v.busy = busy;
    v.chk = 1'b0; v.expOut = 5'd0; v.expStall = 0; v.expFlush = 0;
    return v;
  endfunction

  task automatic addRow(logic rst, logic valid, logic [4:0] rs1,
                        logic [4:0] rs2, logic u1, logic u2, logic [4:0] rd,
                        logic save, logic br, logic busy, logic [4:0] expOut,
                        int expStall, int expFlush);
    vec_t v;
    v = mkVec(rst, valid, rs1, rs2, u1, u2, rd, save, br, busy);
    v.chk = 1'b1; v.expOut = expOut; v.expStall = expStall; v.expFlush = expFlush;
    tbl.push_back(v);
  endtask

  task automatic modelClear(int m);
    for (int r = 0; r < 32; r++) lastWrite[m][r] = -1000;
    flushPrev[m] = 1'b0;
    mStall[m]    = 0;
    mFlush[m]    = 0;
  endtask

  function automatic bit recentWrite(int m, logic [4:0] r);
    int age;
    if (r == 5'd0) return 1'b0;
    age = advCount[m] - lastWrite[m][r];
    return (age >= 1) && (age <= window[m]);
  endfunction

  function automatic logic [4:0] modelOut(int m);
    bit hz;
    hz = dec_valid && ((dec_rs1_used && recentWrite(m, dec_rs1)) ||
                       (dec_rs2_used && recentWrite(m, dec_rs2)));
    if (reset)           return RST;
    if (mem_busy)        return BSY;
    if (ex_branch_taken) return BRN;
    if (flushPrev[m])    return FLS;
    if (hz)              return STL;
    return {4'b1010, dec_valid};
  endfunction

  task automatic modelAdvance();
    logic [4:0] o;
    for (int m = 0; m < 3; m++) begin
      o = modelOut(m);
      if (reset) begin
        modelClear(m);
      end else if (!mem_busy) begin
        if (o[0] && dec_save_to_reg && dec_rd != 5'd0) lastWrite[m][dec_rd] = advCount[m];
        advCount[m]++;
        if (o == STL && mStall[m] < cntMax[m]) mStall[m]++;
        if (ex_branch_taken && mFlush[m] < cntMax[m]) mFlush[m]++;
        flushPrev[m] = ex_branch_taken;
      end
    end
  endtask

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(vec_t v);
    for (int m = 0; m < 3; m++) begin
      checkVal($sformatf("model dut%0d outputs", m), {27'd0, outs[m]}, {27'd0, modelOut(m)});
      checkVal($sformatf("model dut%0d stall_cycles", m), dutStl[m], mStall[m]);
      checkVal($sformatf("model dut%0d flush_events", m), dutFls[m], mFlush[m]);
    end
    if (v.chk) begin
      checkVal("table outputs", {27'd0, outs[0]}, {27'd0, v.expOut});
      checkVal("table stall_cycles", dutStl[0], v.expStall);
      checkVal("table flush_events", dutFls[0], v.expFlush);
    end
  endtask

  // One pipeline cycle: drive, sample at the falling edge, then let the
  // rising edge commit both DUTs and model
  task automatic applyStimulus(vec_t v);
    reset = v.rst; dec_valid = v.valid; dec_rs1 = v.rs1; dec_rs2 = v.rs2;
    dec_rs1_used = v.u1; dec_rs2_used = v.u2; dec_rd = v.rd;
    dec_save_to_reg = v.save; ex_branch_taken = v.br; mem_busy = v.busy;
    @(negedge stg_clk);
    checkOutput(v);
    modelAdvance();
    @(posedge stg_clk);
    #1;
  endtask

  initial begin
    vec_t v;
    for (int m = 0; m < 3; m++) begin
      advCount[m] = 0;
      modelClear(m);
    end
    reset = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0; dec_rd = '0;
    dec_save_to_reg = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge stg_clk);
    #1;

    //      rst v rs1 rs2 u1 u2 rd sv br bz  out  stl fls
    addRow(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
    addRow(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, ISS, 0, 0);
    addRow(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, STL, 0, 0);
    addRow(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, STL, 1, 0);
    addRow(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, STL, 2, 0);
    addRow(0, 1, 5, 0, 1, 0, 6, 1, 0, 0, ISS, 3, 0);
    addRow(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, ISS, 3, 0);
    addRow(0, 1, 0, 0, 1, 0, 7, 1, 0, 0, ISS, 3, 0);
    addRow(0, 1, 0, 7, 0, 0, 0, 0, 0, 0, ISS, 3, 0);
    addRow(0, 1, 7, 0, 1, 0, 0, 0, 0, 0, STL, 3, 0);
    addRow(0, 1, 7, 0, 1, 0, 0, 0, 1, 0, BRN, 4, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLS, 4, 1);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 4, 1);
    addRow(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, ISS, 4, 1);
    addRow(0, 1, 0, 9, 0, 1, 0, 0, 0, 0, STL, 4, 1);
    for (int i = 0; i < 4; i++) addRow(0, 1, 0, 9, 0, 1, 0, 0, 0, 1, BSY, 5, 1);
    addRow(0, 1, 0, 9, 0, 1, 0, 0, 0, 0, STL, 5, 1);
    addRow(0, 1, 0, 9, 0, 1, 0, 0, 0, 0, STL, 6, 1);
    addRow(0, 1, 0, 9, 0, 1, 0, 0, 0, 0, ISS, 7, 1);
    addRow(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, ISS, 7, 1);
    addRow(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, STL, 7, 1);
    addRow(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, RST, 8, 1);
    addRow(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, ISS, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, BSY, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, BRN, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, BRN, 0, 1);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLS, 0, 2);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0, 2);

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Two producer/consumer pairs: 3 stalls each without bypass, 2 with,
    // and the 2-bit counter pins at its maximum
    applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) begin
      applyStimulus(mkVec(0, 1, 0, 0, 0, 0, 4, 1, 0, 0));
      repeat (4) applyStimulus(mkVec(0, 1, 4, 0, 1, 0, 0, 0, 0, 0));
    end
    checkVal("latency stall_cycles no bypass", dutStl[0], 6);
    checkVal("latency stall_cycles bypass", dutStl[1], 4);
    checkVal("saturated stall_cycles", dutStl[2], 3);

    // Random traffic over a small register range so hazards are frequent
    for (int c = 0; c < 600; c++) begin
      v = mkVec($urandom_range(0, 39) == 0, ($urandom % 4) != 0,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                1'($urandom), $urandom_range(0, 11) == 0,
                $urandom_range(0, 9) == 0);
      applyStimulus(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
